alu_share_arbiter: RTL and testbench

- Shares one instance of the existing 8-bit combinational ALU between two requesters (req0, req1) using valid/ready handshakes.
- Arbitration is round-robin; fixed priority is available by parameter.
- Keeps a per-requester carry register so each requester can chain ADD-with-carry across cycles for multi-byte arithmetic.
- Registers the ALU result and flags into a single response slot, tagged with the requester id, with 1-cycle latency.

---
 rtl/alu_ctrl_pkg.sv | 36 +++
 rtl/alu8.sv | 51 +++++
 rtl/rr_arb2.sv | 29 ++
 rtl/alu_share_arbiter.sv | 100 ++++++++++
 tb/tb_alu_share_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, flag indices and the request bundle for the shared ALU
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_INC = 4'h2;
    localparam logic [3:0] OP_DEC = 4'h3;
    localparam logic [3:0] OP_ADC = 4'h4;
    localparam logic [3:0] OP_SBB = 4'h5;
    localparam logic [3:0] OP_CMP = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_XOR = 4'hA;
    localparam logic [3:0] OP_SHL = 4'hB;
    localparam logic [3:0] OP_SHR = 4'hC;
    localparam logic [3:0] OP_ASR = 4'hD;
    localparam logic [3:0] OP_ROL = 4'hE;
    localparam logic [3:0] OP_ROR = 4'hF;

    localparam int FLAG_V = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    localparam logic [3:0] LOGIC_OP_MIN = 4'b0111;

    typedef struct packed {
        logic       mode;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_carry;
    } alu_req_t;

endpackage

// File: rtl/alu8.sv
// alu8: 8-bit combinational ALU with {V,Z,N,C} flags and mode/op legality check
module alu8
    import alu_ctrl_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] f,
    output logic [3:0] flags,
    output logic       err
);

    logic [8:0] sum;
    logic       c;
    logic       v;

    // result in sum[7:0]; sum[8] is carry for adds and borrow for subtracts
    always_comb begin
        sum = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin sum = {1'b0, a} + {1'b0, b}; c = sum[8]; v = ~(a[7] ^ b[7]) & (sum[7] ^ a[7]); end
            OP_SUB: begin sum = {1'b0, a} - {1'b0, b}; c = sum[8]; v = (a[7] ^ b[7]) & (sum[7] ^ a[7]); end
            OP_INC: begin sum = {1'b0, a} + 9'd1; c = sum[8]; v = (a == 8'h7F); end
            OP_DEC: begin sum = {1'b0, a} - 9'd1; c = sum[8]; v = (a == 8'h80); end
            OP_ADC: begin sum = {1'b0, a} + {1'b0, b} + {8'd0, cin}; c = sum[8]; v = ~(a[7] ^ b[7]) & (sum[7] ^ a[7]); end
            OP_SBB: begin sum = {1'b0, a} - {1'b0, b} - {8'd0, cin}; c = sum[8]; v = (a[7] ^ b[7]) & (sum[7] ^ a[7]); end
            OP_CMP: begin sum = {1'b0, a} - {1'b0, b}; c = (a > b); v = (a[7] ^ b[7]) & (sum[7] ^ a[7]); end
            OP_OR:  sum = {1'b0, a | b};
            OP_AND: sum = {1'b0, a & b};
            OP_NOT: sum = {1'b0, ~a};
            OP_XOR: sum = {1'b0, a ^ b};
            OP_SHL: begin sum = {1'b0, a[6:0], 1'b0}; c = a[7]; end
            OP_SHR: begin sum = {2'b00, a[7:1]}; c = a[0]; end
            OP_ASR: begin sum = {1'b0, a[7], a[7:1]}; c = a[0]; end
            OP_ROL: begin sum = {1'b0, a[6:0], a[7]}; c = a[7]; end
            OP_ROR: begin sum = {1'b0, a[0], a[7:1]}; c = a[0]; end
            default: ;
        endcase
        f             = sum[7:0];
        flags[FLAG_V] = v;
        flags[FLAG_Z] = (sum[7:0] == 8'h00);
        flags[FLAG_N] = sum[7];
        flags[FLAG_C] = c;
        err           = mode ? (op < LOGIC_OP_MIN) : (op >= LOGIC_OP_MIN);
    end

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way arbiter, round-robin or fixed priority, remembering the last winner
module rr_arb2 #(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic       gnt_vld,
    output logic       gnt_id
);

    logic last_grant;

    // on contention the requester that did not win last time goes first
    always_comb begin
        gnt_vld = enable & (valid[0] | valid[1]);
        gnt_id  = (&valid) ? ((RR_EN != 0) ? ~last_grant : 1'b0) : valid[1];
    end

    // resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (gnt_vld)
            last_grant <= gnt_id;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters with per-requester carry and a 1-deep response slot
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_mode,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_use_carry,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_mode,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_use_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_f,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err
);

    logic              slot_free;
    logic              gnt_vld;
    logic              gnt_id;
    alu_req_t          sel;
    logic              alu_cin;
    logic [DATA_W-1:0] alu_f;
    logic [3:0]        alu_flags;
    logic              alu_err;
    logic [1:0]        carry_q;

    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   ({req1_valid, req0_valid}),
        .enable  (slot_free & rst_n),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    alu8 u_alu (
        .mode  (sel.mode),
        .op    (sel.op),
        .a     (sel.a),
        .b     (sel.b),
        .cin   (alu_cin),
        .f     (alu_f),
        .flags (alu_flags),
        .err   (alu_err)
    );

    // granted requester steers the ALU; idle cycles present all-zero inputs
    always_comb begin
        slot_free  = !rsp_valid | rsp_ready;
        req0_ready = gnt_vld & ~gnt_id;
        req1_ready = gnt_vld & gnt_id;
        sel        = !gnt_vld ? '0 :
                     gnt_id   ? {req1_mode, req1_op, req1_a, req1_b, req1_use_carry} :
                                {req0_mode, req0_op, req0_a, req0_b, req0_use_carry};
        alu_cin    = sel.use_carry & carry_q[gnt_id];
    end

    // response slot: reload on accept (even while draining), clear on consume alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_f     <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else if (gnt_vld) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_id;
            rsp_f     <= alu_err ? '0 : alu_f;
            rsp_flags <= alu_err ? '0 : alu_flags;
            rsp_err   <= alu_err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // each requester's carry follows only its own legal arithmetic ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            carry_q <= '0;
        else if (gnt_vld & !alu_err & !sel.mode)
            carry_q[gnt_id] <= alu_flags[FLAG_C];
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench for the shared-ALU arbiter
module tb_alu_share_arbiter;
    import alu_ctrl_pkg::*;

    typedef struct packed {
        logic       id;
        logic [7:0] f;
        logic [3:0] flags;
        logic       err;
    } rsp_t;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_mode, req0_use_carry;
    logic [3:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_mode, req1_use_carry;
    logic [3:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic       rsp_ready;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
    logic [7:0] rsp_f;
    logic [3:0] rsp_flags;
    logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_err;
    logic [7:0] fp_rsp_f;
    logic [3:0] fp_rsp_flags;

    int   checks;
    int   failures;
    rsp_t exp_q[$];
    rsp_t e_rsp;
    rsp_t got;
    logic m_valid, m_last, e_acc, e_id, e_mode;
    logic [1:0] m_carry;

    alu_share_arbiter #(.DATA_W(8), .RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_use_carry(req0_use_carry),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_use_carry(req1_use_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    alu_share_arbiter #(.DATA_W(8), .RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_mode(req0_mode), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_use_carry(req0_use_carry),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_mode(req1_mode), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_use_carry(req1_use_carry),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_f(fp_rsp_f),
        .rsp_flags(fp_rsp_flags), .rsp_err(fp_rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask

    // reference ALU built from integer arithmetic
    function automatic rsp_t model(input logic id, input logic mode, input logic [3:0] op,
                                   input logic [7:0] a, input logic [7:0] b, input logic cin);
        int ua, ub, sa, sb, ci, ur, sr;
        logic [7:0] f;
        logic c, v;
        rsp_t r;
        ua = int'(a); ub = int'(b); sa = int'($signed(a)); sb = int'($signed(b)); ci = int'(cin);
        ur = 0; sr = 0; f = 8'h00; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin ur = ua + ub;      sr = sa + sb;      end
            OP_SUB: begin ur = ua - ub;      sr = sa - sb;      end
            OP_INC: begin ur = ua + 1;       sr = sa + 1;       end
            OP_DEC: begin ur = ua - 1;       sr = sa - 1;       end
            OP_ADC: begin ur = ua + ub + ci; sr = sa + sb + ci; end
            OP_SBB: begin ur = ua - ub - ci; sr = sa - sb - ci; end
            OP_CMP: begin ur = ua - ub;      sr = sa - sb;      end
            default: ;
        endcase
        if (op < LOGIC_OP_MIN) begin
            f = ur[7:0];
            v = (sr > 127) || (sr < -128);
            c = (op == OP_CMP) ? (ua > ub) : ((ur > 255) || (ur < 0));
        end else begin
            case (op)
                OP_OR:  f = a | b;
                OP_AND: f = a & b;
                OP_NOT: f = ~a;
                OP_XOR: f = a ^ b;
                OP_SHL: begin f = a << 1; c = a[7]; end
                OP_SHR: begin f = a >> 1; c = a[0]; end
                OP_ASR: begin f = 8'($signed(a) >>> 1); c = a[0]; end
                OP_ROL: begin f = {a[6:0], a[7]}; c = a[7]; end
                OP_ROR: begin f = {a[0], a[7:1]}; c = a[0]; end
                default: ;
            endcase
        end
        r.id    = id;
        r.err   = mode ? (op < LOGIC_OP_MIN) : (op >= LOGIC_OP_MIN);
        r.f     = r.err ? 8'h00 : f;
        r.flags = r.err ? 4'h0 : {v, f == 8'h00, f[7], c};
        return r;
    endfunction

    // predict grants, push expected responses on accept, pop and compare on consume
    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_last  = 1'b1;
            m_carry = 2'b00;
            exp_q.delete();
            chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
            chk("rst_valid", rsp_valid, 1'b0);
        end else begin
            chk("rsp_valid", rsp_valid, m_valid);
            e_acc = (!m_valid || rsp_ready) && (req0_valid || req1_valid);
            e_id  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            chk("ready", {req1_ready, req0_ready}, e_acc ? (e_id ? 2'b10 : 2'b01) : 2'b00);
            if (m_valid && rsp_ready) begin
                if (exp_q.size() == 0)
                    chk("sb_empty", rsp_valid, 1'b0);
                else begin
                    got = exp_q.pop_front();
                    chk("rsp_id", rsp_id, got.id);
                    chk("rsp_f", rsp_f, got.f);
                    chk("rsp_flags", rsp_flags, got.flags);
                    chk("rsp_err", rsp_err, got.err);
                end
            end
            if (e_acc) begin
                e_mode = e_id ? req1_mode : req0_mode;
                e_rsp  = e_id ? model(1'b1, req1_mode, req1_op, req1_a, req1_b, req1_use_carry & m_carry[1])
                              : model(1'b0, req0_mode, req0_op, req0_a, req0_b, req0_use_carry & m_carry[0]);
                exp_q.push_back(e_rsp);
                if (!e_rsp.err && !e_mode)
                    m_carry[e_id] = e_rsp.flags[0];
                m_last  = e_id;
                m_valid = 1'b1;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic setreq(input logic id, input logic mode, input logic [3:0] op,
                          input logic [7:0] a, input logic [7:0] b, input logic uc);
        if (id) begin
            req1_mode = mode; req1_op = op; req1_a = a; req1_b = b; req1_use_carry = uc; req1_valid = 1'b1;
        end else begin
            req0_mode = mode; req0_op = op; req0_a = a; req0_b = b; req0_use_carry = uc; req0_valid = 1'b1;
        end
    endtask

    // present one op and hold it until accepted; returns just after the accept edge
    task automatic send(input logic id, input logic mode, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b, input logic uc);
        int n;
        setreq(id, mode, op, a, b, uc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? req1_ready : req0_ready) && n < 50);
        chk("send_accept", id ? req1_ready : req0_ready, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_mode = 1'b0; req0_op = 4'h0; req0_a = 8'h00; req0_b = 8'h00; req0_use_carry = 1'b0;
        req1_valid = 1'b0; req1_mode = 1'b0; req1_op = 4'h0; req1_a = 8'h00; req1_b = 8'h00; req1_use_carry = 1'b0;
        req0_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_id", rsp_id, 1'b0);
        chk("reset_rsp_f", rsp_f, 8'h00);
        chk("reset_rsp_flags", rsp_flags, 4'h0);
        chk("reset_rsp_err", rsp_err, 1'b0);
        chk("reset_ready0", req0_ready, 1'b0);
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(1'b0, 1'b0, OP_ADD, 8'h7F, 8'h01, 1'b0);
        chk("add_valid", rsp_valid, 1'b1);
        chk("add_id", rsp_id, 1'b0);
        chk("add_f", rsp_f, 8'h80);
        chk("add_flags", rsp_flags, 4'b1010);

        send(1'b1, 1'b0, OP_ADD, 8'hFF, 8'h01, 1'b0);
        chk("chain_add_f", rsp_f, 8'h00);
        chk("chain_add_flags", rsp_flags, 4'b0101);
        send(1'b0, 1'b0, OP_ADD, 8'hFF, 8'h01, 1'b0);
        send(1'b1, 1'b0, OP_ADC, 8'h00, 8'h00, 1'b1);
        chk("chain_adc_f", rsp_f, 8'h01);
        chk("chain_adc_flags", rsp_flags, 4'b0000);
        send(1'b0, 1'b0, OP_ADD, 8'hFF, 8'h01, 1'b0);
        send(1'b1, 1'b0, OP_ADD, 8'h01, 8'h01, 1'b0);
        send(1'b0, 1'b0, OP_ADC, 8'h00, 8'h00, 1'b1);
        chk("iso_adc0_f", rsp_f, 8'h01);

        send(1'b0, 1'b0, OP_ADD, 8'hFF, 8'h01, 1'b0);
        send(1'b0, 1'b0, OP_AND, 8'h55, 8'h0F, 1'b0);
        chk("illegal_err", rsp_err, 1'b1);
        chk("illegal_f", rsp_f, 8'h00);
        chk("illegal_flags", rsp_flags, 4'h0);
        send(1'b0, 1'b0, OP_ADC, 8'h00, 8'h00, 1'b1);
        chk("illegal_carry_kept", rsp_f, 8'h01);
        send(1'b0, 1'b0, OP_CMP, 8'h09, 8'h03, 1'b0);
        send(1'b0, 1'b0, OP_ADC, 8'h10, 8'h00, 1'b1);
        chk("cmp_carry_gt", rsp_f, 8'h11);

        send(1'b1, 1'b0, OP_INC, 8'h01, 8'h00, 1'b0);
        setreq(1'b0, 1'b0, OP_ADD, 8'h01, 8'h02, 1'b0);
        setreq(1'b1, 1'b0, OP_ADD, 8'h03, 8'h04, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("fair_rr", {req1_ready, req0_ready}, (i % 2 == 1) ? 2'b10 : 2'b01);
            chk("fair_fixed", {fp_req1_ready, fp_req0_ready}, 2'b01);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        send(1'b0, 1'b0, OP_SUB, 8'h10, 8'h20, 1'b0);
        setreq(1'b1, 1'b1, OP_AND, 8'hF0, 8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", {req1_ready, req0_ready}, 2'b00);
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_f", rsp_f, 8'hF0);
            chk("bp_flags", rsp_flags, 4'b0011);
            chk("bp_id", rsp_id, 1'b0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_accept", req1_ready, 1'b1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_reload_valid", rsp_valid, 1'b1);
        chk("bp_reload_id", rsp_id, 1'b1);
        chk("bp_reload_f", rsp_f, 8'h30);
        @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            req0_valid = 1'($urandom_range(0, 1)); req0_mode = 1'($urandom_range(0, 1));
            req0_op = 4'($urandom_range(0, 15)); req0_a = 8'($urandom_range(0, 255));
            req0_b = 8'($urandom_range(0, 255)); req0_use_carry = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1)); req1_mode = 1'($urandom_range(0, 1));
            req1_op = 4'($urandom_range(0, 15)); req1_a = 8'($urandom_range(0, 255));
            req1_b = 8'($urandom_range(0, 255)); req1_use_carry = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send(1'b0, 1'b0, OP_ADD, 8'hFF, 8'h01, 1'b0);
        send(1'b1, 1'b0, OP_ADD, 8'hFF, 8'h01, 1'b0);
        setreq(1'b0, 1'b0, OP_ADD, 8'h01, 8'h01, 1'b0);
        setreq(1'b1, 1'b0, OP_ADD, 8'h02, 8'h02, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", rsp_valid, 1'b0);
        chk("midrst_ready", {req1_ready, req0_ready}, 2'b00);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_first_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        send(1'b0, 1'b0, OP_ADC, 8'h00, 8'h00, 1'b1);
        chk("midrst_carry0", rsp_f, 8'h00);
        send(1'b1, 1'b0, OP_ADC, 8'h00, 8'h00, 1'b1);
        chk("midrst_carry1", rsp_f, 8'h00);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
